// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int OPCODE_LSB   = 0;
  localparam int OPCODE_MSB   = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs; flush empties it and wins over push/pop.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, buffered responses, branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_5
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_pc;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          pop;
  logic          push;
  logic          issue_idle;
  logic          issue_b2b;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign next_pc     = fetch_pc + INSTR_BYTES;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign push        = (state == WAIT) && imem_rvalid && !redirect;

  // A back-to-back request may use the slot the current pop is freeing.
  assign issue_idle = !rst && !redirect && (state == IDLE) && (count < DEPTH_C);
  assign issue_b2b  = !rst && !redirect && (state == WAIT) && imem_rvalid &&
                      ((count < DEPTH_M1) || pop);

  assign imem_req  = issue_idle || issue_b2b;
  assign imem_addr = issue_b2b ? next_pc : fetch_pc;

  // fetch_pc always names the word of the outstanding (or next) request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      state    <= (state != IDLE && !imem_rvalid) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue_idle) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            fetch_pc <= next_pc;
            state    <= issue_b2b ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({fetch_pc, imem_rdata}),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

  assign instr    = head[31:0];
  assign instr_pc = head[63:32];
  assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_5 = instr[FUNCT7_5_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable memory model plus an in-order delivery scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic [6:0]  opcode2;
  logic [2:0]  funct3_2;
  logic        funct7_5_2;

  int          tests = 0;
  int          fails = 0;
  int          delivered = 0;
  int          lat = 1;
  int          cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] paddr = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] req_log[$];
  logic [31:0] wrap_log[$];
  bit          found;
  bit          stray;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .instr_valid(valid2), .instr_ready(ready2),
    .instr(instr2), .instr_pc(instr_pc2), .opcode(opcode2), .funct3(funct3_2),
    .funct7_5(funct7_5_2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 10) ^ (a << 26);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    instr_ready = ready;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic push_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: start + 32'(4 * i), word: mem_word(start + 32'(4 * i))});
    end
  endtask

  // Memory with configurable latency; a response still arrives if reset hits mid-request.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (pending) begin
      if (cnt <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(paddr);
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (imem_req) begin
      req_log.push_back(imem_addr);
      paddr = imem_addr;
      if (lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
      end else begin
        pending = 1'b1;
        cnt     = lat - 1;
      end
    end
  end

  always @(posedge clk) begin
    rvalid2 <= req2;
    rdata2  <= mem_word(addr2);
    if (req2) wrap_log.push_back(addr2);
  end

  // Every accepted head must match the next expected word of the stream.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_delivery", instr_pc, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("deliv_pc", instr_pc, mon_e.pc);
        checkOutput("deliv_instr", instr, mon_e.word);
        checkOutput("deliv_opcode", 32'(opcode), 32'(mon_e.word[6:0]));
        checkOutput("deliv_funct3", 32'(funct3), 32'(mon_e.word[14:12]));
        checkOutput("deliv_funct7_5", 32'(funct7_5), 32'(mon_e.word[30]));
      end
      delivered++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values and first-fetch latency with a stalled decoder.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_pc", instr_pc, 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("c1_req", 32'(imem_req), 32'd1);
    checkOutput("c1_addr", imem_addr, 32'h0);
    @(negedge clk);
    checkOutput("c2_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    checkOutput("c3_valid", 32'(instr_valid), 32'd1);
    checkOutput("c3_instr", instr, 32'h0050_0093);
    checkOutput("c3_pc", instr_pc, 32'h0);
    checkOutput("c3_opcode", 32'(opcode), 32'h13);
    checkOutput("c3_funct3", 32'(funct3), 32'd0);
    checkOutput("c3_funct7_5", 32'(funct7_5), 32'd0);
    repeat (7) @(negedge clk);
    checkOutput("stall_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      checkOutput("stall_req0", req_log[0], 32'h0);
      checkOutput("stall_req1", req_log[1], 32'h4);
    end

    // Release the stall: 0x0, 0x4, 0x8 must come out in order.
    push_stream(32'h0);
    delivered = 0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("release_delivered", 32'(delivered >= 3), 32'd1);

    // Slow memory, redirect while a request to 0x8 is outstanding.
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    lat = 3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_stream(32'h0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    checkOutput("reach_req8", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h100);
    push_stream(32'h100);
    delivered = 0;
    @(negedge clk);
    checkOutput("redir_no_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_flushed", 32'(instr_valid), 32'd0);
    checkOutput("redir_state_drop", 32'(dut.state), 32'(DROP));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    checkOutput("drop_next_req_seen", 32'(found), 32'd1);
    checkOutput("drop_next_req_addr", imem_addr, 32'h100);

    // Redirect to an unaligned target in the same cycle as a response.
    found = 1'b0;
    for (int i = 0; i < 40 && delivered < 1; i++) @(negedge clk);
    checkOutput("first_0x100_delivered", 32'(delivered >= 1), 32'd1);
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (imem_rvalid) found = 1'b1;
    end
    checkOutput("rvalid_seen", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    push_stream(32'h200);
    delivered = 0;
    @(negedge clk);
    checkOutput("redir_rv_no_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_rv_req", 32'(imem_req), 32'd1);
    checkOutput("redir_rv_addr", imem_addr, 32'h200);
    checkOutput("redir_rv_empty", 32'(instr_valid), 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("deliv_after_0x200", 32'(delivered >= 2), 32'd1);

    // Reset mid-request with an entry buffered; the late response must be ignored.
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_stream(32'h0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (dut.state == WAIT && instr_valid) found = 1'b1;
    end
    checkOutput("reach_wait_buffered", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_req", 32'(imem_req), 32'd0);
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (imem_rvalid) stray = 1'b1;
    end
    checkOutput("stray_rvalid_seen", 32'(stray), 32'd1);
    checkOutput("stray_ignored", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_stream(32'h0);
    @(negedge clk);
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h0);
    delivered = 0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (15) @(negedge clk);
    checkOutput("restart_delivered", 32'(delivered >= 2), 32'd1);

    // PC wrap from a high reset vector.
    wrap_log.delete();
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("wrap_req_count", 32'(wrap_log.size() >= 3), 32'd1);
    if (wrap_log.size() >= 3) begin
      checkOutput("wrap_addr0", wrap_log[0], 32'hFFFF_FFF8);
      checkOutput("wrap_addr1", wrap_log[1], 32'hFFFF_FFFC);
      checkOutput("wrap_addr2", wrap_log[2], 32'h0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
